// File: rtl/q_bias_fetch_ctrl.sv
// Q-projection bias fetch sequencer.
// Walks a window of output channels four at a time and drives the four read
// ports of the bias ROM. Each 128-bit group is registered into a single output
// slot and handed downstream over valid/ready with full backpressure.

// Per-lane slice: read-address adder plus this lane's word of the output slot.
module q_bias_lane #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LANE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ptr,
  input  logic              load,
  input  logic [DATA_W-1:0] rom_word,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word
);
  // Channel index wraps modulo the ROM depth (truncating add).
  assign addr = ptr + ADDR_W'(LANE);

  // Capture this lane's ROM word whenever the slot is reloaded; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       word <= '0;
    else if (load) word <= rom_word;
  end
endmodule

module q_bias_fetch_ctrl #(
  parameter int N_CH   = 128,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base,
  input  logic [4:0]              n_groups,
  output logic [ADDR_W-1:0]       a1,
  output logic [ADDR_W-1:0]       a2,
  output logic [ADDR_W-1:0]       a3,
  output logic [ADDR_W-1:0]       a4,
  input  logic [LANES*DATA_W-1:0] rom_bias,
  output logic                    bias_valid,
  input  logic                    bias_ready,
  output logic [LANES*DATA_W-1:0] bias_out,
  output logic [4:0]              group_idx,
  output logic                    busy,
  output logic                    done
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [5:0]        remaining;   // 1..32, so one extra bit over n_groups
  logic [4:0]        gcnt;        // only indices 0..31 are ever presented
  logic              slot_free;
  logic              load;
  logic              xfer;

  logic [LANES-1:0][ADDR_W-1:0] addr;
  logic [LANES-1:0][DATA_W-1:0] word;

  assign xfer      = bias_valid & bias_ready;
  assign slot_free = ~bias_valid | bias_ready;
  assign load      = (state == ST_RUN) & slot_free;
  assign busy      = (state != ST_IDLE);

  // One lane slice per ROM read port.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    q_bias_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE(k)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ptr      (ptr),
      .load     (load),
      .rom_word (rom_bias[k*DATA_W +: DATA_W]),
      .addr     (addr[k]),
      .word     (word[k])
    );
  end

  assign a1       = addr[0];
  assign a2       = addr[1];
  assign a3       = addr[2];
  assign a4       = addr[3];
  assign bias_out = word;

  // Run sequencing: window pointer, group counters and state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      remaining <= '0;
      gcnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          ptr       <= base;
          remaining <= (n_groups == 5'd0) ? 6'd32 : {1'b0, n_groups};
          gcnt      <= '0;
          state     <= ST_RUN;
        end
        ST_RUN: if (slot_free) begin
          ptr       <= ptr + ADDR_W'(LANES);
          gcnt      <= gcnt + 5'd1;
          remaining <= remaining - 6'd1;
          if (remaining == 6'd1) state <= ST_DRAIN;
        end
        ST_DRAIN: if (xfer) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output slot valid/index and the end-of-run pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_valid <= 1'b0;
      group_idx  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        bias_valid <= 1'b1;
        group_idx  <= gcnt;
      end else if (state == ST_DRAIN && xfer) begin
        bias_valid <= 1'b0;
        done       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_q_bias_fetch_ctrl.sv
// Scoreboard bench for q_bias_fetch_ctrl: expected groups are queued at start,
// a negedge monitor pops and compares on every accepted transfer.
module tb_q_bias_fetch_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [6:0]   base = '0;
  logic [4:0]   n_groups = '0;
  logic [6:0]   a1, a2, a3, a4;
  logic [127:0] rom_bias;
  logic         bias_valid;
  logic         bias_ready = 1'b1;
  logic [127:0] bias_out;
  logic [4:0]   group_idx;
  logic         busy, done;

  q_bias_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .n_groups(n_groups),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .rom_bias(rom_bias),
    .bias_valid(bias_valid), .bias_ready(bias_ready), .bias_out(bias_out),
    .group_idx(group_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM model: mem[i] = i
  always_comb rom_bias = {25'd0, a4, 25'd0, a3, 25'd0, a2, 25'd0, a1};

  typedef struct packed {
    logic [4:0]   idx;
    logic [127:0] data;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int n_pass = 0, n_tot = 0, done_cnt = 0, bp = 0, rc = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  task automatic kick(input int b, input int ng);
    int nn;
    logic [127:0] d;
    nn = (ng == 0) ? 32 : ng;
    for (int g = 0; g < nn; g++) begin
      for (int k = 0; k < 4; k++) d[32*k +: 32] = 32'((b + 4*g + k) % 128);
      q.push_back({5'(g), d});
    end
    base = 7'(b); n_groups = 5'(ng); start = 1'b1;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 400) begin @(posedge clk); #1; c++; end
    chk("done_seen", done, 1);
  endtask

  task automatic run(input int b, input int ng, input bit lat);
    int c;
    kick(b, ng);
    @(posedge clk); #1 start = 1'b0;
    wait_done(c);
    if (lat) chk("run_latency", c, ((ng == 0) ? 32 : ng) + 1);
    chk("sb_empty", q.size(), 0);
    chk("busy_low_at_done", busy, 0);
  endtask

  // Consumer ready: always high, or pattern 1,0,0,1,0,0,... under backpressure.
  initial forever begin
    @(posedge clk); #1;
    rc++;
    bias_ready = (bp == 0) ? 1'b1 : (rc % 3 == 0);
  end

  // Monitor: transfers, stall stability, done exclusivity.
  logic         pstall = 1'b0;
  logic [127:0] pout;
  logic [4:0]   pidx;
  logic [6:0]   pa1;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (done) begin
        done_cnt++;
        chk("done_excl_valid", bias_valid, 0);
      end
      if (pstall) begin
        chk("stall_data", bias_out, pout);
        chk("stall_idx", group_idx, pidx);
        chk("stall_addr", a1, pa1);
      end
      if (bias_valid && bias_ready) begin
        if (q.size() == 0) chk("unexpected_group", 1, 0);
        else begin
          e = q.pop_front();
          chk("grp_data", bias_out, e.data);
          chk("grp_idx", group_idx, e.idx);
        end
      end
      pstall = bias_valid && !bias_ready;
      pout = bias_out; pidx = group_idx; pa1 = a1;
    end else pstall = 1'b0;
  end

  initial begin
    int c, dc;
    repeat (2) @(posedge clk);
    #1;
    // reset values
    chk("rst_addr", {a4, a3, a2, a1}, {7'd3, 7'd2, 7'd1, 7'd0});
    chk("rst_valid", bias_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", bias_out, 0);
    chk("rst_idx", group_idx, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // full sweep
    run(0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    // wrap past channel 127
    run(126, 2, 1);
    repeat (3) @(posedge clk);
    #1;
    // backpressure
    bp = 1;
    run(8, 3, 0);
    bp = 0;
    repeat (3) @(posedge clk);
    #1;

    // start while busy is ignored
    dc = done_cnt;
    kick(32, 4);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 base = 7'd64; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(c);
    repeat (5) @(posedge clk);
    #1;
    chk("ign_busy", busy, 0);
    chk("ign_valid", bias_valid, 0);
    chk("ign_sb_empty", q.size(), 0);
    chk("ign_done_once", done_cnt, dc + 1);

    // reset mid-run during group 5
    kick(0, 0);
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (!(bias_valid && group_idx == 5'd5) && c < 100) begin @(negedge clk); c++; end
    chk("reach_grp5", group_idx, 5);
    rst = 1'b1;
    #1;
    chk("mrst_addr", {a4, a3, a2, a1}, {7'd3, 7'd2, 7'd1, 7'd0});
    chk("mrst_valid", bias_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_out", bias_out, 0);
    chk("mrst_idx", group_idx, 0);
    q.delete();
    dc = done_cnt;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_done", done_cnt, dc);
    run(0, 1, 1);

    // back-to-back: second start issued in the done cycle
    repeat (3) @(posedge clk);
    #1;
    run(16, 2, 1);
    kick(40, 1);
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_valid0", bias_valid, 0);
    @(posedge clk); #1;
    chk("b2b_valid1", bias_valid, 1);
    chk("b2b_addr_out", bias_out[31:0], 40);
    wait_done(c);
    chk("b2b_sb_empty", q.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
